fixed_div: RTL and testbench

- Sequential signed fixed-point divider; it is the inverse operation of the team's fixed-point multiplier (FPmul) and uses the same WI/WF format parameterisation.
- Computes quotient = A / B, where A is in Q(WI1.WF1), B is in Q(WI2.WF2), and the result is in Q(WIO.WFO).
- Uses a restoring radix-2 algorithm: one quotient bit per clock, with a start/busy/done handshake.
- Saturates on overflow and flags underflow and divide-by-zero. Used in the datapath wherever the multiplier's inverse is required.

---
 rtl/fixed_div.sv | 175 +++++++++++++++++
 tb/tb_fixed_div.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fixed_div.sv
// ============================================================================
// fixed_div : sequential signed fixed-point divider (restoring, 1 bit/clock)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_div #(
  parameter int WI1 = 5,
  parameter int WF1 = 14,
  parameter int WI2 = 3,
  parameter int WF2 = 14,
  parameter int WIO = 8,
  parameter int WFO = 14
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic signed [WI1+WF1-1:0]   A,
  input  logic signed [WI2+WF2-1:0]   B,
  output logic                        busy,
  output logic                        done,
  output logic signed [WIO+WFO-1:0]   quotient,
  output logic                        overflow,
  output logic                        underflow,
  output logic                        div_by_zero
);

  localparam int WA = WI1 + WF1;
  localparam int WB = WI2 + WF2;
  localparam int WO = WIO + WFO;
  localparam int SH = WFO + WF2 - WF1;
  localparam int WD = WA + SH;
  localparam int WC = ((WD > WO) ? WD : WO) + 1;
  localparam int CW = $clog2(WD + 1);

  localparam logic [WC-1:0] MAXP_MAG = (WC'(1) << (WO - 1)) - WC'(1);
  localparam logic [WC-1:0] MAXN_MAG = WC'(1) << (WO - 1);
  localparam logic [WO-1:0] MAXP_Q   = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MAXN_Q   = {1'b1, {(WO-1){1'b0}}};

  if (WFO + WF2 < WF1) begin : g_fmt_err
    $error("fixed_div: WFO+WF2 must be >= WF1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [WD-1:0]   acc_q;
  logic [WB-1:0]   rem_q;
  logic [WB-1:0]   babs_q;
  logic            neg_q;
  logic            a_neg_q;
  logic            a_nz_q;
  logic            bz_q;

  // Same-width two's-complement negation yields the correct unsigned
  // magnitude even for the most negative input.
  logic [WA-1:0]   abs_a;
  logic [WB-1:0]   abs_b;
  assign abs_a = A[WA-1] ? WA'(-A) : WA'(A);
  assign abs_b = B[WB-1] ? WB'(-B) : WB'(B);

  // acc_q holds the aligned dividend; quotient bits enter at the LSB as
  // dividend bits leave at the MSB.
  logic [WB:0]     rem_sh;
  logic            ge;
  logic [WB-1:0]   rem_d;
  logic [WD-1:0]   acc_d;
  assign rem_sh = {rem_q, acc_q[WD-1]};
  assign ge     = (rem_sh >= {1'b0, babs_q});
  assign rem_d  = ge ? WB'(rem_sh - {1'b0, babs_q}) : rem_sh[WB-1:0];
  assign acc_d  = {acc_q[WD-2:0], ge};

  logic [WC-1:0]   mag;
  logic [WO-1:0]   q_fin;
  logic            ovf_fin;
  logic            unf_fin;
  assign mag = WC'(acc_q);

  always_comb begin
    q_fin   = '0;
    ovf_fin = 1'b0;
    unf_fin = 1'b0;
    if (bz_q) begin
      if (a_nz_q) begin
        ovf_fin = 1'b1;
        q_fin   = a_neg_q ? MAXN_Q : MAXP_Q;
      end
    end else if (!neg_q && (mag > MAXP_MAG)) begin
      ovf_fin = 1'b1;
      q_fin   = MAXP_Q;
    end else if (neg_q && (mag > MAXN_MAG)) begin
      ovf_fin = 1'b1;
      q_fin   = MAXN_Q;
    end else begin
      q_fin   = neg_q ? WO'(-mag) : WO'(mag);
      unf_fin = a_nz_q && (acc_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      babs_q      <= '0;
      neg_q       <= 1'b0;
      a_neg_q     <= 1'b0;
      a_nz_q      <= 1'b0;
      bz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            neg_q       <= A[WA-1] ^ B[WB-1];
            a_neg_q     <= A[WA-1];
            a_nz_q      <= (A != '0);
            bz_q        <= (B == '0);
            acc_q       <= WD'(abs_a) << SH;
            babs_q      <= abs_b;
            rem_q       <= '0;
            // A zero divisor skips every iteration and only waits out the
            // single finalisation cycle.
            cnt_q       <= (B == '0) ? CW'(WD - 1) : '0;
            busy        <= 1'b1;
            quotient    <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            state_q     <= S_DIV;
          end
        end
        S_DIV: begin
          if (cnt_q == CW'(WD)) begin
            quotient    <= q_fin;
            overflow    <= ovf_fin;
            underflow   <= unf_fin;
            div_by_zero <= bz_q;
            done        <= 1'b1;
            busy        <= 1'b0;
            state_q     <= S_FIN;
          end else begin
            if (!bz_q) begin
              acc_q <= acc_d;
              rem_q <= rem_d;
            end
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_div.sv
// ============================================================================
// tb_fixed_div : directed + random self-checking bench for fixed_div
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fixed_div;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic signed [18:0]  A     = '0;
  logic signed [16:0]  B     = '0;
  wire                 busy;
  wire                 done;
  wire signed [21:0]   quotient;
  wire                 overflow;
  wire                 underflow;
  wire                 div_by_zero;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fixed_div #(
    .WI1(5), .WF1(14), .WI2(3), .WF2(14), .WIO(8), .WFO(14)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .overflow   (overflow),
    .underflow  (underflow),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int flags();
    return int'({overflow, underflow, div_by_zero});
  endfunction

  // ef = {overflow, underflow, div_by_zero}; elat = edge index of done.
  task automatic do_op(input string tag, input int a, input int b,
                       input longint eq, input int ef, input int elat);
    int lat;
    @(negedge clk);
    A = 19'(a);
    B = 17'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"},   lat, elat);
    chk({tag, "_q"},     quotient, eq);
    chk({tag, "_flags"}, flags(), ef);
    chk({tag, "_busy"},  busy, 0);
    @(posedge clk); #1;
    chk({tag, "_done1"}, done, 0);
  endtask

  initial begin
    int t1, t2, ndone, lat;
    longint q1, q2;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl",   int'({busy, done}), 0);
    chk("rst_q",     quotient, 0);
    chk("rst_flags", flags(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("basic",   49152,   24576,   32768,    0, 34);
    do_op("neg75",   -122880, 32768,   -61440,   0, 34);
    do_op("third",   16384,   49152,   5461,     0, 34);
    do_op("nthird",  -16384,  49152,   -5461,    0, 34);
    do_op("ovf",     245760,  1,       2097151,  4, 34);
    do_op("unf",     1,       57344,   0,        2, 34);
    do_op("dz_neg",  -16384,  0,       -2097152, 5, 2);
    do_op("dz_zero", 0,       0,       0,        1, 2);
    do_op("dz_pos",  16384,   0,       2097151,  5, 2);
    do_op("maxn_ok", -262144, 2048,    -2097152, 0, 34);
    do_op("maxp_sat",-262144, -2048,   2097151,  4, 34);
    do_op("bmin",    16384,   -65536,  -4096,    0, 34);
    do_op("a_zero",  0,       16384,   0,        0, 34);

    // start re-asserted at edge 5 (DIV) and during the done cycle (FIN)
    @(negedge clk);
    A = 19'sd49152; B = 17'sd24576; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; lat = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (lat < 0) lat = i;
      end
      start = (i == 4) || (i == lat);
      if (start) begin
        A = -19'sd1000;
        B = 17'sd3;
      end
    end
    start = 1'b0;
    chk("hs_lat",   lat, 34);
    chk("hs_ndone", ndone, 1);
    chk("hs_q",     quotient, 32768);

    // start held high across two operations
    @(negedge clk);
    A = 19'sd16384; B = 17'sd49152; start = 1'b1;
    t1 = -1; t2 = -1; q1 = 0; q2 = 0;
    for (int i = 0; i <= 110; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (t1 < 0) begin
          t1 = i; q1 = quotient; A = -19'sd16384;
        end else if (t2 < 0) begin
          t2 = i; q2 = quotient;
        end
      end
      if (t1 >= 0 && i == t1 + 2) start = 1'b0;
    end
    start = 1'b0;
    chk("b2b_t1", t1, 34);
    chk("b2b_q1", q1, 5461);
    chk("b2b_t2", t2, 70);
    chk("b2b_q2", q2, -5461);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    A = 19'sd49152; B = 17'sd24576; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy_pre", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl",   int'({busy, done}), 0);
    chk("mid_rst_q",     quotient, 0);
    chk("mid_rst_flags", flags(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mid_no_done", ndone, 0);
    do_op("post_rst", 49152, 24576, 32768, 0, 34);

    for (int k = 0; k < 1000; k++) begin
      logic signed [18:0] ra;
      logic signed [16:0] rb;
      longint am, bm, m, eq;
      int ef;
      bit neg;
      ra = 19'($urandom);
      rb = 17'($urandom);
      if (k % 5 == 0) ra = ra >>> 10;
      if (k % 3 == 0) rb = 17'($urandom_range(16384, 65535));
      if (rb == 0) rb = 17'sd1;
      am  = (ra < 0) ? -longint'(ra) : longint'(ra);
      bm  = (rb < 0) ? -longint'(rb) : longint'(rb);
      m   = (am * 16384) / bm;
      neg = (ra < 0) ^ (rb < 0);
      if (!neg && m > 2097151) begin
        eq = 2097151;  ef = 4;
      end else if (neg && m > 2097152) begin
        eq = -2097152; ef = 4;
      end else begin
        eq = neg ? -m : m;
        ef = (ra != 0 && m == 0) ? 2 : 0;
      end
      do_op("rnd", int'(ra), int'(rb), eq, ef, 34);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
